instruction_queue: RTL and testbench
====================================

# instruction_queue

Circular FIFO between the instruction fetch stage and the decode/dispatch stage. Buffers fetched `{pc, instruction}` entries so fetch can run ahead of dispatch, exposes a valid/ready handshake on both sides, and supports a single-cycle flush on branch redirect.

## Interface

**Parameters**
- `INST_WIDTH`, default 32: instruction width in bits.
- `ADDR_WIDTH`, default 17: program counter width in bits.
- `DEPTH_LOG`, default 4: log2 of the entry count (16 entries).

**Ports**
- `clk`, input, 1: the single clock; all state changes on the rising edge.
- `rst_n`, input, 1: asynchronous, active-low reset.
- `rdy`, input, 1: global enable; when low, no state changes.
- `flush`, input, 1: discard all entries, including any concurrent push.
- `in_valid`, input, 1: the fetch stage presents an entry.
- `in_entry`, input, `ADDR_WIDTH+INST_WIDTH`: `{pc, inst}`; the instruction is in the low bits.
- `in_ready`, output, 1: the queue accepts a push this cycle.
- `out_valid`, output, 1: the head entry is valid.
- `out_entry`, output, `ADDR_WIDTH+INST_WIDTH`: the head entry, same layout as `in_entry`.
- `out_ready`, input, 1: the consumer takes the head this cycle.
- `count`, output, `DEPTH_LOG+1`: number of occupied entries.

## Operation

**State**
- Storage array of `2^DEPTH_LOG` entries.
- `head` and `tail` pointers, `DEPTH_LOG` bits each.
- `count` register, `DEPTH_LOG+1` bits.

**Outputs**
- `in_ready = (count != 2^DEPTH_LOG)`, derived combinationally from registered `count` only.
  - There is no full-queue pass-through: when full, `in_ready` stays 0 even if a pop occurs in the same cycle.
- `out_valid = (count != 0)`.
- `out_entry = mem[head]`, read combinationally.

**Events** (evaluated at the rising edge with `rdy=1`)
- Push: `in_valid && in_ready`. Write `mem[tail]`, then `tail <= tail+1`.
- Pop: `out_valid && out_ready`. `head <= head+1`.
- Count update:
  - push only: `count+1`
  - pop only: `count-1`
  - both: `count` unchanged
  - neither: hold
- Priority: `flush` overrides push and pop. `head`, `tail` and `count` all go to 0; storage contents are don't-care.
- Pointers wrap modulo `2^DEPTH_LOG` through natural overflow; no explicit compare.

**`rdy` low**
- All registers hold.
- Outputs keep their combinational values, so upstream may see `ready` and `valid` high, but no transfer occurs.

**Reset**
- `rst_n` low asynchronously clears `head`, `tail` and `count`.
- After reset: `in_ready=1`, `out_valid=0`, `count=0`. `out_entry` is don't-care.
- Reset asserted mid-operation drops all entries immediately, without waiting for a clock edge.

## Timing

- Push-to-output latency is one cycle: an entry written at edge N is visible on `out_entry` with `out_valid=1` after edge N when the queue was empty.
- Throughput is one push and one pop per cycle sustained, at any occupancy from 1 to `2^DEPTH_LOG - 1`.
- At full occupancy:
  - A pop frees a slot that is visible on `in_ready` after that edge.
  - Maximum throughput is therefore one push every cycle only while the queue is not full.
- Flush:
  - Asserted at edge N: after edge N, `out_valid=0` and `in_ready=1`.
  - A push presented in the same cycle as the flush is lost; the fetch stage must re-present the redirected pc.
- Handshake signals are sampled only at the rising edge. `in_entry` need only be stable around the edge where `in_valid && in_ready`.

## Test plan

1. **Reset:** assert `rst_n=0` asynchronously between edges → `count=0`, `out_valid=0`, `in_ready=1` immediately, with no clock edge needed.
2. **Fill and drain:** push 16 entries with pc `0x0`, `0x4`, …, `0x3C` and `out_ready=0` → `count=16`, `in_ready=0`. A 17th push is ignored. Then set `out_ready=1` → entries emerge in order pc `0x0` … `0x3C`, after which `out_valid=0`.
3. **Simultaneous push/pop plus wrap:** keep 3 entries resident, then push and pop together for 40 cycles → `count` stays 3, the pointers wrap twice, and the output pc sequence is strictly increasing by 4 with no loss or duplication.
4. **Full with concurrent pop:** with `count=16`, drive `out_ready=1` and `in_valid=1` → that cycle pops only (`in_ready=0`), leaving `count=15`. The next cycle the push is accepted.
5. **Flush:** with `count=5`, assert `flush` together with `in_valid=1` and `out_ready=1` → after the edge `count=0`, `out_valid=0`, and the concurrent entry is not stored.
6. **`rdy` gating:** with `count=2`, set `rdy=0` for 4 cycles while `in_valid=1` and `out_ready=1` → `count` stays 2 and `out_entry` is unchanged. On `rdy=1`, normal transfers resume.

Source files
------------

// File: rtl/instruction_queue.sv
// Circular FIFO buffering {pc, inst} entries between fetch and decode/dispatch.
// Valid/ready on both sides, a global rdy enable, and a single-cycle flush for branch redirect.
module instruction_queue #(
  parameter int INST_WIDTH = 32,
  parameter int ADDR_WIDTH = 17,
  parameter int DEPTH_LOG  = 4
) (
  input  logic                             clk,
  input  logic                             rst_n,
  input  logic                             rdy,
  input  logic                             flush,
  input  logic                             in_valid,
  input  logic [ADDR_WIDTH+INST_WIDTH-1:0] in_entry,
  output logic                             in_ready,
  output logic                             out_valid,
  output logic [ADDR_WIDTH+INST_WIDTH-1:0] out_entry,
  input  logic                             out_ready,
  output logic [DEPTH_LOG:0]               count
);

  localparam int DEPTH = 1 << DEPTH_LOG;
  localparam int EW    = ADDR_WIDTH + INST_WIDTH;

  localparam logic [DEPTH_LOG:0]   CNT_FULL = {1'b1, {DEPTH_LOG{1'b0}}};
  localparam logic [DEPTH_LOG:0]   CNT_ONE  = 1;
  localparam logic [DEPTH_LOG-1:0] PTR_ONE  = 1;

  logic [EW-1:0]        mem_q [DEPTH];
  logic [DEPTH_LOG-1:0] head_q, head_d;
  logic [DEPTH_LOG-1:0] tail_q, tail_d;
  logic [DEPTH_LOG:0]   count_q, count_d;
  logic                 push, pop;

  // Readiness comes from the registered count only: no pass-through when full.
  assign in_ready  = (count_q != CNT_FULL);
  assign out_valid = (count_q != '0);
  assign out_entry = mem_q[head_q];
  assign count     = count_q;

  assign push = rdy && !flush && in_valid  && in_ready;
  assign pop  = rdy && !flush && out_valid && out_ready;

  always_comb begin
    head_d  = head_q;
    tail_d  = tail_q;
    count_d = count_q;
    if (rdy && flush) begin
      head_d  = '0;
      tail_d  = '0;
      count_d = '0;
    end else begin
      if (push) tail_d = tail_q + PTR_ONE;
      if (pop)  head_d = head_q + PTR_ONE;
      case ({push, pop})
        2'b10:   count_d = count_q + CNT_ONE;
        2'b01:   count_d = count_q - CNT_ONE;
        default: count_d = count_q;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      head_q  <= '0;
      tail_q  <= '0;
      count_q <= '0;
    end else begin
      head_q  <= head_d;
      tail_q  <= tail_d;
      count_q <= count_d;
    end
  end

  // Storage is not reset; contents are meaningless until written.
  always_ff @(posedge clk) begin
    if (push) mem_q[tail_q] <= in_entry;
  end

endmodule

// File: tb/tb_instruction_queue.sv
// Self-checking bench for instruction_queue: directed scenarios plus randomized traffic
// checked against a queue-based reference model.
module tb_instruction_queue;

  localparam int IW = 32;
  localparam int AW = 17;
  localparam int DL = 4;
  localparam int EW = IW + AW;
  localparam int DEPTH = 16;

  logic          clk;
  logic          rst_n;
  logic          rdy;
  logic          flush;
  logic          in_valid;
  logic [EW-1:0] in_entry;
  logic          in_ready;
  logic          out_valid;
  logic [EW-1:0] out_entry;
  logic          out_ready;
  logic [DL:0]   count;

  int checks;
  int failures;

  logic [EW-1:0] mq[$];

  instruction_queue #(
    .INST_WIDTH(IW),
    .ADDR_WIDTH(AW),
    .DEPTH_LOG (DL)
  ) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .rdy      (rdy),
    .flush    (flush),
    .in_valid (in_valid),
    .in_entry (in_entry),
    .in_ready (in_ready),
    .out_valid(out_valid),
    .out_entry(out_entry),
    .out_ready(out_ready),
    .count    (count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [EW-1:0] mkent(input int unsigned pc);
    logic [AW-1:0] p;
    logic [IW-1:0] ins;
    p   = pc[AW-1:0];
    ins = $urandom;
    return {p, ins};
  endfunction

  // Advance one clock edge and apply the transfer rules to the model.
  task automatic tick();
    bit            p, q, f;
    logic [EW-1:0] e;
    f = rdy && flush;
    p = rdy && !flush && in_valid && (mq.size() != DEPTH);
    q = rdy && !flush && out_ready && (mq.size() != 0);
    e = in_entry;
    @(posedge clk);
    if (f) mq.delete();
    else begin
      if (q) void'(mq.pop_front());
      if (p) mq.push_back(e);
    end
    #1;
  endtask

  task automatic idle_inputs();
    rdy = 1'b1; flush = 1'b0; in_valid = 1'b0; out_ready = 1'b0; in_entry = '0;
  endtask

  task automatic clear();
    idle_inputs();
    #2 rst_n = 1'b0;
    mq.delete();
    #2 rst_n = 1'b1;
    tick();
  endtask

  task automatic push_n(input int n, input int unsigned pc0);
    in_valid = 1'b1; out_ready = 1'b0;
    for (int i = 0; i < n; i++) begin
      in_entry = mkent(pc0 + 4 * i);
      tick();
    end
    in_valid = 1'b0;
  endtask

  task automatic test_reset();
    clear();
    push_n(3, 32'h200);
    #2 rst_n = 1'b0;
    mq.delete();
    #1;
    checks++;
    if (count !== '0) begin failures++; $display("FAIL reset_count actual=%0d expected=0", count); end
    checks++;
    if (out_valid !== 1'b0) begin failures++; $display("FAIL reset_out_valid actual=%b expected=0", out_valid); end
    checks++;
    if (in_ready !== 1'b1) begin failures++; $display("FAIL reset_in_ready actual=%b expected=1", in_ready); end
    #1 rst_n = 1'b1;
    tick();
  endtask

  task automatic test_fill_drain();
    clear();
    push_n(16, 0);
    checks++;
    if (count !== 5'd16) begin failures++; $display("FAIL fill_count actual=%0d expected=16", count); end
    checks++;
    if (in_ready !== 1'b0) begin failures++; $display("FAIL fill_in_ready actual=%b expected=0", in_ready); end
    in_valid = 1'b1; in_entry = mkent(32'h40);
    tick();
    in_valid = 1'b0;
    checks++;
    if (count !== 5'd16) begin failures++; $display("FAIL push17_count actual=%0d expected=16", count); end
    out_ready = 1'b1;
    for (int i = 0; i < 16; i++) begin
      checks++;
      if (out_valid !== 1'b1 || out_entry !== mq[0] || out_entry[EW-1:IW] !== AW'(4 * i)) begin
        failures++;
        $display("FAIL drain_order[%0d] actual_valid=%b actual=%h expected_pc=%h", i, out_valid, out_entry, 4 * i);
      end
      tick();
    end
    checks++;
    if (out_valid !== 1'b0) begin failures++; $display("FAIL drained_out_valid actual=%b expected=0", out_valid); end
    out_ready = 1'b0;
  endtask

  task automatic test_back_to_back_wrap();
    int unsigned exp_pc;
    int unsigned next_pc;
    clear();
    push_n(3, 0);
    exp_pc = 0; next_pc = 12;
    in_valid = 1'b1; out_ready = 1'b1;
    for (int i = 0; i < 40; i++) begin
      in_entry = mkent(next_pc);
      checks++;
      if (out_entry[EW-1:IW] !== AW'(exp_pc) || out_entry !== mq[0]) begin
        failures++;
        $display("FAIL wrap_pc[%0d] actual=%h expected_pc=%h", i, out_entry[EW-1:IW], exp_pc);
      end
      tick();
      exp_pc += 4; next_pc += 4;
      checks++;
      if (count !== 5'd3) begin failures++; $display("FAIL wrap_count[%0d] actual=%0d expected=3", i, count); end
    end
    idle_inputs();
  endtask

  task automatic test_full_pop();
    clear();
    push_n(16, 32'h1000);
    in_valid = 1'b1; out_ready = 1'b1; in_entry = mkent(32'h1040);
    checks++;
    if (in_ready !== 1'b0) begin failures++; $display("FAIL fullpop_in_ready actual=%b expected=0", in_ready); end
    tick();
    checks++;
    if (count !== 5'd15) begin failures++; $display("FAIL fullpop_count actual=%0d expected=15", count); end
    checks++;
    if (in_ready !== 1'b1) begin failures++; $display("FAIL fullpop_in_ready_after actual=%b expected=1", in_ready); end
    out_ready = 1'b0;
    tick();
    checks++;
    if (count !== 5'd16) begin failures++; $display("FAIL fullpop_push_count actual=%0d expected=16", count); end
    in_valid = 1'b0; out_ready = 1'b1;
    for (int i = 0; i < 16; i++) begin
      checks++;
      if (out_entry !== mq[0]) begin failures++; $display("FAIL fullpop_drain[%0d] actual=%h expected=%h", i, out_entry, mq[0]); end
      tick();
    end
    idle_inputs();
  endtask

  task automatic test_flush();
    logic [EW-1:0] fresh;
    clear();
    push_n(5, 32'h300);
    flush = 1'b1; in_valid = 1'b1; out_ready = 1'b1; in_entry = mkent(32'h1234);
    tick();
    flush = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
    checks++;
    if (count !== '0) begin failures++; $display("FAIL flush_count actual=%0d expected=0", count); end
    checks++;
    if (out_valid !== 1'b0 || in_ready !== 1'b1) begin
      failures++; $display("FAIL flush_flags actual_valid=%b actual_ready=%b expected 0/1", out_valid, in_ready);
    end
    fresh = mkent(32'h500);
    in_valid = 1'b1; in_entry = fresh;
    tick();
    in_valid = 1'b0;
    checks++;
    if (count !== 5'd1 || out_entry !== fresh) begin
      failures++; $display("FAIL flush_repush actual_count=%0d actual=%h expected=%h", count, out_entry, fresh);
    end
  endtask

  task automatic test_rdy_gating();
    logic [EW-1:0] head;
    clear();
    push_n(2, 32'h700);
    head = mq[0];
    rdy = 1'b0; in_valid = 1'b1; out_ready = 1'b1; in_entry = mkent(32'h708);
    for (int i = 0; i < 4; i++) begin
      tick();
      checks++;
      if (count !== 5'd2 || out_entry !== head) begin
        failures++; $display("FAIL rdy_hold[%0d] actual_count=%0d actual=%h expected=%h", i, count, out_entry, head);
      end
    end
    rdy = 1'b1;
    tick();
    checks++;
    if (count !== 5'd2 || out_entry !== mq[0] || out_entry[EW-1:IW] !== AW'(32'h704)) begin
      failures++; $display("FAIL rdy_resume actual_count=%0d actual=%h expected=%h", count, out_entry, mq[0]);
    end
    idle_inputs();
  endtask

  task automatic test_random();
    int unsigned pc;
    clear();
    pc = 32'h8000;
    for (int i = 0; i < 400; i++) begin
      rdy       = ($urandom_range(0, 9) != 0);
      flush     = ($urandom_range(0, 29) == 0);
      in_valid  = ($urandom_range(0, 3) != 0);
      out_ready = ($urandom_range(0, 2) != 0);
      in_entry  = mkent(pc);
      pc += 4;
      tick();
      checks++;
      if (count !== (DL+1)'(mq.size()) || out_valid !== (mq.size() != 0) || in_ready !== (mq.size() != DEPTH)) begin
        failures++;
        $display("FAIL rand_state[%0d] actual_count=%0d valid=%b ready=%b expected_count=%0d", i, count, out_valid, in_ready, mq.size());
      end
      if (mq.size() != 0) begin
        checks++;
        if (out_entry !== mq[0]) begin failures++; $display("FAIL rand_head[%0d] actual=%h expected=%h", i, out_entry, mq[0]); end
      end
    end
    idle_inputs();
  endtask

  initial begin
    checks = 0; failures = 0;
    idle_inputs();
    rst_n = 1'b0;
    #12 rst_n = 1'b1;
    tick();
    test_reset();
    test_fill_drain();
    test_back_to_back_wrap();
    test_full_pop();
    test_flush();
    test_rdy_gating();
    test_random();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
